// File: rtl/swbtn_input_conditioner.sv
// Switch/button conditioner: 2-FF sync, counter debounce, sticky W1C press flags, press counter.
// Optional interrupt output enabled by defining SWBTN_IRQ_EN.
module swbtn_input_conditioner #(
  parameter int unsigned NUM_SW          = 4,
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic [NUM_SW-1:0]  sw_in,
  input  logic [NUM_BTN-1:0] btn_in,
  input  logic [NUM_BTN-1:0] clr_pending,
  output logic [NUM_SW-1:0]  sw_state,
  output logic [NUM_BTN-1:0] btn_state,
  output logic [NUM_BTN-1:0] btn_pending,
`ifdef SWBTN_IRQ_EN
  input  logic [NUM_BTN-1:0] irq_mask,
  output logic               irq,
`endif
  output logic [CNT_W-1:0]   press_cnt
);

  localparam int unsigned NUM = NUM_SW + NUM_BTN;
  localparam int unsigned DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DCW-1:0] LAST = DCW'(DEBOUNCE_CYCLES - 1);

  // Switches occupy the low bits, buttons the high bits of every per-input vector.
  logic [NUM-1:0]     raw;
  logic [NUM-1:0]     s1;
  logic [NUM-1:0]     s2;
  logic [NUM-1:0]     state_q;
  logic [NUM-1:0]     state_d;
  logic [DCW-1:0]     cnt_q [NUM];
  logic [DCW-1:0]     cnt_d [NUM];
  logic [NUM_BTN-1:0] btn_q;
  logic [NUM_BTN-1:0] btn_d;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] pending_q;
  logic [NUM_BTN-1:0] pending_d;
  logic [CNT_W-1:0]   rise_cnt;
  logic [CNT_W-1:0]   press_q;

  assign raw = {btn_in, sw_in};

  always_comb begin
    state_d = state_q;
    for (int unsigned i = 0; i < NUM; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2[i] == state_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == LAST) begin
        state_d[i] = s2[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DCW'(1);
      end
    end
  end

  assign btn_q     = state_q[NUM-1:NUM_SW];
  assign btn_d     = state_d[NUM-1:NUM_SW];
  assign rise      = btn_d & ~btn_q;
  // A rise in the same cycle as a clear re-sets the flag.
  assign pending_d = (pending_q & ~clr_pending) | rise;

  always_comb begin
    rise_cnt = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      rise_cnt = rise_cnt + CNT_W'(rise[i]);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      s1        <= '0;
      s2        <= '0;
      state_q   <= '0;
      pending_q <= '0;
      press_q   <= '0;
      for (int unsigned i = 0; i < NUM; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1        <= raw;
      s2        <= s1;
      state_q   <= state_d;
      pending_q <= pending_d;
      press_q   <= press_q + rise_cnt;
      for (int unsigned i = 0; i < NUM; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef SWBTN_IRQ_EN
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      irq <= 1'b0;
    end else begin
      irq <= |(pending_d & irq_mask);
    end
  end
`endif

  assign sw_state    = state_q[NUM_SW-1:0];
  assign btn_state   = btn_q;
  assign btn_pending = pending_q;
  assign press_cnt   = press_q;

endmodule

// File: tb/tb_swbtn_input_conditioner.sv
// Directed bench for swbtn_input_conditioner (DEBOUNCE_CYCLES=4, CNT_W=4).
// Define SWBTN_IRQ_EN for both files to exercise the interrupt output.
module tb_swbtn_input_conditioner;

  logic       ACLK;
  logic       ARESETN;
  logic [3:0] sw_in;
  logic [3:0] btn_in;
  logic [3:0] clr_pending;
  logic [3:0] sw_state;
  logic [3:0] btn_state;
  logic [3:0] btn_pending;
  logic [3:0] press_cnt;
`ifdef SWBTN_IRQ_EN
  logic [3:0] irq_mask;
  logic       irq;
`endif

  int total = 0;
  int bad   = 0;

  swbtn_input_conditioner #(
    .NUM_SW(4),
    .NUM_BTN(4),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(4)
  ) dut (
    .ACLK(ACLK),
    .ARESETN(ARESETN),
    .sw_in(sw_in),
    .btn_in(btn_in),
    .clr_pending(clr_pending),
    .sw_state(sw_state),
    .btn_state(btn_state),
    .btn_pending(btn_pending),
`ifdef SWBTN_IRQ_EN
    .irq_mask(irq_mask),
    .irq(irq),
`endif
    .press_cnt(press_cnt)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic test_reset;
    ARESETN = 1'b0; sw_in = '0; btn_in = '0; clr_pending = '0;
`ifdef SWBTN_IRQ_EN
    irq_mask = '0;
`endif
    tick(3);
    total++;
    if ({sw_state, btn_state, btn_pending, press_cnt} !== 16'h0000) begin
      bad++; $display("FAIL reset_hold: got %h want 0000", {sw_state, btn_state, btn_pending, press_cnt});
    end
    ARESETN = 1'b1;
    tick(3);
    total++;
    if ({sw_state, btn_state, btn_pending, press_cnt} !== 16'h0000) begin
      bad++; $display("FAIL reset_idle: got %h want 0000", {sw_state, btn_state, btn_pending, press_cnt});
    end
`ifdef SWBTN_IRQ_EN
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
`endif
  endtask

  // The first edge after driving counts as edge 1; the new level appears on edge 6.
  task automatic test_switch;
    sw_in = 4'b0101;
    tick(5);
    total++;
    if (sw_state !== 4'b0000) begin bad++; $display("FAIL sw_early: got %b want 0000", sw_state); end
    tick(1);
    total++;
    if (sw_state !== 4'b0101) begin bad++; $display("FAIL sw_settle: got %b want 0101", sw_state); end
    total++;
    if ({btn_state, btn_pending, press_cnt} !== 12'h000) begin
      bad++; $display("FAIL sw_btn_quiet: got %h want 000", {btn_state, btn_pending, press_cnt});
    end
  endtask

  task automatic test_bounce;
    logic [4:0] seq;
    seq = 5'b01101;
    for (int k = 0; k < 5; k++) begin
      btn_in[0] = seq[k];
      tick(1);
      total++;
      if (btn_state !== 4'b0000) begin bad++; $display("FAIL bounce_%0d: got %b want 0000", k, btn_state); end
    end
    btn_in[0] = 1'b1;
    tick(5);
    total++;
    if (btn_state !== 4'b0000) begin bad++; $display("FAIL press_early: got %b want 0000", btn_state); end
    tick(1);
    total++;
    if (btn_state !== 4'b0001) begin bad++; $display("FAIL press_state: got %b want 0001", btn_state); end
    total++;
    if (btn_pending !== 4'b0001) begin bad++; $display("FAIL press_pending: got %b want 0001", btn_pending); end
    total++;
    if (press_cnt !== 4'd1) begin bad++; $display("FAIL press_cnt1: got %0d want 1", press_cnt); end
  endtask

  task automatic test_set_wins;
    btn_in[0] = 1'b0;
    tick(6);
    total++;
    if ({btn_state, btn_pending} !== 8'h01) begin
      bad++; $display("FAIL release_keeps_pending: got %h want 01", {btn_state, btn_pending});
    end
    btn_in[0] = 1'b1;
    tick(5);
    clr_pending = 4'b0001;
    tick(1);
    total++;
    if ({btn_state, btn_pending} !== 8'h11) begin
      bad++; $display("FAIL set_beats_clr: got %h want 11", {btn_state, btn_pending});
    end
    tick(1);
    total++;
    if (btn_pending !== 4'b0000) begin bad++; $display("FAIL clr_alone: got %b want 0000", btn_pending); end
    tick(1);
    clr_pending = '0;
    total++;
    if (btn_pending !== 4'b0000) begin bad++; $display("FAIL clr_idle: got %b want 0000", btn_pending); end
    total++;
    if (press_cnt !== 4'd2) begin bad++; $display("FAIL press_cnt2: got %0d want 2", press_cnt); end
  endtask

  task automatic test_async_reset;
    @(posedge ACLK);
    #3;
    ARESETN = 1'b0;
    #1;
    total++;
    if ({sw_state, btn_state, btn_pending, press_cnt} !== 16'h0000) begin
      bad++; $display("FAIL async_reset: got %h want 0000", {sw_state, btn_state, btn_pending, press_cnt});
    end
    sw_in = '0; btn_in = '0;
    tick(2);
    ARESETN = 1'b1;
    tick(2);
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_cnt;
    exp_cnt = '0;
    for (int r = 0; r < 4; r++) begin
      btn_in = 4'b1111;
      tick(6);
      exp_cnt = exp_cnt + 4'd4;
      total++;
      if (press_cnt !== exp_cnt) begin bad++; $display("FAIL wrap_cnt_%0d: got %0d want %0d", r, press_cnt, exp_cnt); end
      total++;
      if (btn_state !== 4'b1111) begin bad++; $display("FAIL wrap_state_%0d: got %b want 1111", r, btn_state); end
      btn_in = 4'b0000;
      tick(6);
      total++;
      if (btn_state !== 4'b0000 || press_cnt !== exp_cnt) begin
        bad++; $display("FAIL wrap_release_%0d: got %b/%0d want 0000/%0d", r, btn_state, press_cnt, exp_cnt);
      end
    end
  endtask

`ifdef SWBTN_IRQ_EN
  task automatic test_irq;
    clr_pending = 4'b1111;
    tick(1);
    clr_pending = '0;
    irq_mask = 4'b0010;
    tick(1);
    total++;
    if ({btn_pending, 3'b000, irq} !== 8'h00) begin
      bad++; $display("FAIL irq_idle: got %b/%b want 0000/0", btn_pending, irq);
    end
    btn_in = 4'b0001;
    tick(6);
    total++;
    if (btn_pending !== 4'b0001 || irq !== 1'b0) begin
      bad++; $display("FAIL irq_masked: got %b/%b want 0001/0", btn_pending, irq);
    end
    btn_in = 4'b0011;
    tick(5);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_early: got %b want 0", irq); end
    tick(1);
    total++;
    if (btn_pending !== 4'b0011 || irq !== 1'b1) begin
      bad++; $display("FAIL irq_set: got %b/%b want 0011/1", btn_pending, irq);
    end
    clr_pending = 4'b0010;
    tick(1);
    clr_pending = '0;
    total++;
    if (btn_pending !== 4'b0001 || irq !== 1'b0) begin
      bad++; $display("FAIL irq_clr: got %b/%b want 0001/0", btn_pending, irq);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_switch();
    test_bounce();
    test_set_wins();
    test_async_reset();
    test_back_to_back();
`ifdef SWBTN_IRQ_EN
    test_irq();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
